stopwatch_time_counter: RTL and testbench

//   Count-side responder for the stopwatch control FSM's CLKEN/RST outputs.

---
 rtl/stopwatch_time_counter_pkg.sv | 28 ++
 rtl/stopwatch_time_counter_if.sv | 25 ++
 rtl/stopwatch_time_counter_bcd_digit_cnt.sv | 38 +++
 rtl/stopwatch_time_counter.sv | 112 +++++++++++
 tb/tb_stopwatch_time_counter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_time_counter_pkg.sv
// Shared constants and types for the stopwatch count side: digit width,
// per-digit terminal values and the default prescale for a 10 MHz clock.
package stopwatch_time_counter_pkg;

    localparam int DIG_W            = 4;
    localparam int N_DIGITS         = 5;
    localparam int DEFAULT_PRESCALE = 1000000;
    localparam int DEFAULT_PS_W     = 20;

    typedef logic [DIG_W-1:0] digit_t;

    localparam digit_t DIG_MOD10 = 4'd9;
    localparam digit_t DIG_MOD6  = 4'd5;

    typedef struct packed {
        digit_t min_tens;
        digit_t min_ones;
        digit_t sec_tens;
        digit_t sec_ones;
        digit_t tenths;
    } sw_time_t;

    // Digit order is tenths(0), sec_ones(1), sec_tens(2), min_ones(3), min_tens(4).
    function automatic digit_t digit_max(input int idx);
        return (idx == 2 || idx == 4) ? DIG_MOD6 : DIG_MOD10;
    endfunction

endpackage

// File: rtl/stopwatch_time_counter_if.sv
// Control inputs from the stopwatch FSM and display outputs toward the LCD driver.
interface stopwatch_time_counter_if;
    import stopwatch_time_counter_pkg::*;

    logic   RST;
    logic   CLKEN;
    logic   LAP;
    digit_t TENTHS;
    digit_t SEC_ONES;
    digit_t SEC_TENS;
    digit_t MIN_ONES;
    digit_t MIN_TENS;
    logic   HOLD;
    logic   WRAP;

    modport master (
        output RST, CLKEN, LAP,
        input  TENTHS, SEC_ONES, SEC_TENS, MIN_ONES, MIN_TENS, HOLD, WRAP
    );

    modport slave (
        input  RST, CLKEN, LAP,
        output TENTHS, SEC_ONES, SEC_TENS, MIN_ONES, MIN_TENS, HOLD, WRAP
    );
endinterface

// File: rtl/stopwatch_time_counter_bcd_digit_cnt.sv
// One BCD digit counter: counts 0..MAX on en, wraps to 0 and raises co at MAX.
module bcd_digit_cnt
    import stopwatch_time_counter_pkg::*;
#(
    parameter digit_t MAX = DIG_MOD10
) (
    input  logic   CLK,
    input  logic   RESET,
    input  logic   clr,
    input  logic   en,
    output digit_t q,
    output logic   co
);

    digit_t q_q;
    digit_t q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = (q_q == MAX) ? '0 : q_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            q_q <= '0;
        end else if (clr) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign co = en & (q_q == MAX);

endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch count side: 0.1 s prescaler, MM:SS.t BCD chain, lap hold and
// rollover pulse feeding the display digits.
module stopwatch_time_counter
    import stopwatch_time_counter_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE,
    parameter int PS_W     = DEFAULT_PS_W
) (
    input  logic CLK,
    input  logic RESET,
    stopwatch_time_counter_if.slave bus
);

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q;
    logic [PS_W-1:0] ps_d;
    logic            tick;

    digit_t   live [N_DIGITS];
    sw_time_t live_time;
    sw_time_t lap_q;
    sw_time_t lap_d;
    sw_time_t disp;
    logic     hold_q;
    logic     hold_d;
    logic     wrap_q;

    // Prescaler freezes while stopped so a restart resumes the partial tick.
    always_comb begin
        ps_d = ps_q;
        tick = 1'b0;
        if (bus.CLKEN) begin
            if (ps_q == PS_LAST) begin
                ps_d = '0;
                tick = 1'b1;
            end else begin
                ps_d = ps_q + 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            logic en;
            logic co;

            if (gi == 0) begin : g_first
                assign en = tick;
            end else begin : g_next
                assign en = g_digit[gi-1].co;
            end

            bcd_digit_cnt #(
                .MAX (digit_max(gi))
            ) u_cnt (
                .CLK   (CLK),
                .RESET (RESET),
                .clr   (bus.RST),
                .en    (en),
                .q     (live[gi]),
                .co    (co)
            );
        end
    endgenerate

    assign live_time = {live[4], live[3], live[2], live[1], live[0]};

    // First LAP snapshots the registered live value; the second releases the hold.
    always_comb begin
        lap_d  = lap_q;
        hold_d = hold_q;
        if (bus.LAP) begin
            if (hold_q) begin
                hold_d = 1'b0;
            end else begin
                lap_d  = live_time;
                hold_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ps_q   <= '0;
            lap_q  <= '0;
            hold_q <= 1'b0;
            wrap_q <= 1'b0;
        end else if (bus.RST) begin
            ps_q   <= '0;
            lap_q  <= '0;
            hold_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            ps_q   <= ps_d;
            lap_q  <= lap_d;
            hold_q <= hold_d;
            wrap_q <= g_digit[N_DIGITS-1].co;
        end
    end

    assign disp = hold_q ? lap_q : live_time;

    assign bus.TENTHS   = disp.tenths;
    assign bus.SEC_ONES = disp.sec_ones;
    assign bus.SEC_TENS = disp.sec_tens;
    assign bus.MIN_ONES = disp.min_ones;
    assign bus.MIN_TENS = disp.min_tens;
    assign bus.HOLD     = hold_q;
    assign bus.WRAP     = wrap_q;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Bench for stopwatch_time_counter: a fast-prescale instance for general behaviour
// and a minimum-prescale instance to reach the 59:59.9 rollover.
module tb_stopwatch_time_counter;

    localparam int PS_MAIN = 4;
    localparam int PS_WRAP = 2;
    localparam int HOUR_DS = 36000;   // deciseconds in one full 60-minute span

    logic clk = 1'b0;
    logic reset;
    logic [1:0] rst_v;
    logic [1:0] clken_v;
    logic [1:0] lap_v;
    logic [21:0] obs [2];

    // Behavioural model: elapsed time kept as plain deciseconds per instance.
    int m_phase [2];
    int m_total [2];
    int m_lap   [2];
    bit m_hold  [2];
    bit m_wrap  [2];

    int n_checks = 0;
    int n_fail   = 0;

    bit          lit_tog  = 1'b0;
    bit          lit_seen = 1'b0;
    string       lit_name;
    int          lit_inst;
    logic [21:0] lit_exp;
    logic [21:0] exp_v;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_inst
            stopwatch_time_counter_if bus ();

            stopwatch_time_counter #(
                .PRESCALE ((gi == 0) ? PS_MAIN : PS_WRAP),
                .PS_W     (3)
            ) u_dut (
                .CLK   (clk),
                .RESET (reset),
                .bus   (bus.slave)
            );

            assign bus.RST   = rst_v[gi];
            assign bus.CLKEN = clken_v[gi];
            assign bus.LAP   = lap_v[gi];
            assign obs[gi]   = {bus.MIN_TENS, bus.MIN_ONES, bus.SEC_TENS, bus.SEC_ONES,
                                bus.TENTHS, bus.HOLD, bus.WRAP};
        end
    endgenerate

    function automatic int presc(input int k);
        return (k == 0) ? PS_MAIN : PS_WRAP;
    endfunction

    function automatic logic [19:0] to_bcd(input int ds);
        return {4'(ds / 6000), 4'((ds / 600) % 10), 4'((ds / 100) % 6),
                4'((ds / 10) % 10), 4'(ds % 10)};
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset || rst_v[k]) begin
                m_phase[k] <= 0;
                m_total[k] <= 0;
                m_lap[k]   <= 0;
                m_hold[k]  <= 1'b0;
                m_wrap[k]  <= 1'b0;
            end else begin
                if (lap_v[k]) begin
                    if (!m_hold[k]) begin
                        m_lap[k]  <= m_total[k];
                        m_hold[k] <= 1'b1;
                    end else begin
                        m_hold[k] <= 1'b0;
                    end
                end
                m_wrap[k] <= clken_v[k] && (m_phase[k] == presc(k) - 1) && (m_total[k] == HOUR_DS - 1);
                if (clken_v[k]) begin
                    m_phase[k] <= (m_phase[k] + 1) % presc(k);
                end
                if (clken_v[k] && (m_phase[k] == presc(k) - 1)) begin
                    m_total[k] <= (m_total[k] + 1) % HOUR_DS;
                end
            end
        end
    end

    // Single checker: model comparison every falling edge, literal checks on request.
    always @(negedge clk or lit_tog) begin
        if (lit_tog != lit_seen) begin
            lit_seen = lit_tog;
            n_checks++;
            if (obs[lit_inst] !== lit_exp) begin
                n_fail++;
                $display("FAIL %s: dut=%h required=%h", lit_name, obs[lit_inst], lit_exp);
            end else begin
                $display("ok   %s: %h", lit_name, obs[lit_inst]);
            end
        end else if (!clk) begin
            for (int k = 0; k < 2; k++) begin
                exp_v = {to_bcd(m_hold[k] ? m_lap[k] : m_total[k]), m_hold[k], m_wrap[k]};
                n_checks++;
                if (obs[k] !== exp_v) begin
                    n_fail++;
                    $display("FAIL model_cycle inst%0d t=%0t: dut=%h required=%h", k, $time, obs[k], exp_v);
                end
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic expect_lit(input string name, input int inst,
                              input int mt, input int mo, input int st, input int so,
                              input int t, input bit h, input bit w);
        lit_name = name;
        lit_inst = inst;
        lit_exp  = {4'(mt), 4'(mo), 4'(st), 4'(so), 4'(t), h, w};
        lit_tog  = ~lit_tog;
        #1;
    endtask

    task automatic clear_main();
        rst_v[0] = 1'b1;
        run(1);
        rst_v[0] = 1'b0;
    endtask

    initial begin
        rst_v   = 2'b00;
        clken_v = 2'b00;
        lap_v   = 2'b00;
        #1 reset = 1'b1;
        run(2);
        expect_lit("reset_main", 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        expect_lit("reset_wrap_inst", 1, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        reset = 1'b0;

        // Ten ticks at four cycles each
        clken_v[0] = 1'b1;
        run(4);
        expect_lit("t1_first_tick", 0, 0, 0, 0, 0, 1, 1'b0, 1'b0);
        run(32);
        expect_lit("t1_tick9", 0, 0, 0, 0, 0, 9, 1'b0, 1'b0);
        run(4);
        expect_lit("t1_tick10_carry", 0, 0, 0, 0, 1, 0, 1'b0, 1'b0);

        // Stop/restart keeps the partial prescale count
        clken_v[0] = 1'b0;
        clear_main();
        expect_lit("t2_cleared", 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        clken_v[0] = 1'b1;
        run(2);
        clken_v[0] = 1'b0;
        run(20);
        expect_lit("t2_paused", 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        clken_v[0] = 1'b1;
        run(2);
        expect_lit("t2_resumed_one_tick", 0, 0, 0, 0, 0, 1, 1'b0, 1'b0);
        clken_v[0] = 1'b0;

        // Full rollover on the minimum-prescale instance
        clken_v[1] = 1'b1;
        run(71998);
        expect_lit("t3_at_59_59_9", 1, 5, 9, 5, 9, 9, 1'b0, 1'b0);
        run(2);
        expect_lit("t3_wrap_pulse", 1, 0, 0, 0, 0, 0, 1'b0, 1'b1);
        run(1);
        expect_lit("t3_wrap_cleared", 1, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        run(1);
        expect_lit("t3_counting_on", 1, 0, 0, 0, 0, 1, 1'b0, 1'b0);
        clken_v[1] = 1'b0;

        // Lap hold while running
        clear_main();
        clken_v[0] = 1'b1;
        run(136);
        expect_lit("t4_live_3_4", 0, 0, 0, 0, 3, 4, 1'b0, 1'b0);
        lap_v[0] = 1'b1;
        run(1);
        lap_v[0] = 1'b0;
        expect_lit("t4_hold_set", 0, 0, 0, 0, 3, 4, 1'b1, 1'b0);
        run(31);
        expect_lit("t4_frozen", 0, 0, 0, 0, 3, 4, 1'b1, 1'b0);
        lap_v[0] = 1'b1;
        run(1);
        lap_v[0] = 1'b0;
        expect_lit("t4_release_4_2", 0, 0, 0, 0, 4, 2, 1'b0, 1'b0);

        // LAP coinciding with a tick captures the pre-increment value
        clear_main();
        run(23);
        expect_lit("t5_before", 0, 0, 0, 0, 0, 5, 1'b0, 1'b0);
        lap_v[0] = 1'b1;
        run(1);
        lap_v[0] = 1'b0;
        expect_lit("t5_lap_0_5", 0, 0, 0, 0, 0, 5, 1'b1, 1'b0);
        lap_v[0] = 1'b1;
        run(1);
        lap_v[0] = 1'b0;
        expect_lit("t5_live_0_6", 0, 0, 0, 0, 0, 6, 1'b0, 1'b0);

        // RST while holding, mid-prescale; then async RESET mid-cycle
        clear_main();
        run(3336);
        expect_lit("t6_live_1_23_4", 0, 0, 1, 2, 3, 4, 1'b0, 1'b0);
        lap_v[0] = 1'b1;
        run(1);
        lap_v[0] = 1'b0;
        run(1);
        expect_lit("t6_held", 0, 0, 1, 2, 3, 4, 1'b1, 1'b0);
        rst_v[0] = 1'b1;
        run(1);
        rst_v[0] = 1'b0;
        expect_lit("t6_rst_clears", 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        run(3);
        expect_lit("t6_prescaler_restarted", 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        run(1);
        expect_lit("t6_first_tick", 0, 0, 0, 0, 0, 1, 1'b0, 1'b0);
        run(2);
        reset = 1'b1;
        #1;
        expect_lit("t6_async_reset", 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        run(1);
        reset = 1'b0;
        run(4);
        expect_lit("t6_after_reset_tick", 0, 0, 0, 0, 0, 1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
